// File: rtl/l2_port_arbiter_if.sv
// l2_port_arbiter_if: bundles the I-cache pmem port, the D-cache pmem port
// and the L2 mem port that the arbiter joins.
//   master : the surrounding system (both L1 caches plus the L2 cache)
//   slave  : the arbiter itself
interface l2_port_arbiter_if;
  logic         arb_icache_read;
  logic         arb_icache_write;
  logic [31:0]  arb_icache_address;
  logic [255:0] arb_icache_wdata;
  logic [255:0] arb_icache_rdata;
  logic         arb_icache_resp;

  logic         arb_dcache_read;
  logic         arb_dcache_write;
  logic [31:0]  arb_dcache_address;
  logic [255:0] arb_dcache_wdata;
  logic [255:0] arb_dcache_rdata;
  logic         arb_dcache_resp;

  logic         arb_mem_read;
  logic         arb_mem_write;
  logic [31:0]  arb_mem_address;
  logic [255:0] arb_mem_wdata;
  logic [255:0] arb_mem_rdata;
  logic         arb_mem_resp;

  modport master (
    output arb_icache_read, arb_icache_write, arb_icache_address, arb_icache_wdata,
    input  arb_icache_rdata, arb_icache_resp,
    output arb_dcache_read, arb_dcache_write, arb_dcache_address, arb_dcache_wdata,
    input  arb_dcache_rdata, arb_dcache_resp,
    input  arb_mem_read, arb_mem_write, arb_mem_address, arb_mem_wdata,
    output arb_mem_rdata, arb_mem_resp
  );

  modport slave (
    input  arb_icache_read, arb_icache_write, arb_icache_address, arb_icache_wdata,
    output arb_icache_rdata, arb_icache_resp,
    input  arb_dcache_read, arb_dcache_write, arb_dcache_address, arb_dcache_wdata,
    output arb_dcache_rdata, arb_dcache_resp,
    output arb_mem_read, arb_mem_write, arb_mem_address, arb_mem_wdata,
    input  arb_mem_rdata, arb_mem_resp
  );
endinterface

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the single L2 line port between the I-cache and
// D-cache. D wins contested grants until STARVE_LIMIT consecutive contested
// D grants have been made, then I is forced. One line transaction at a time.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   bus (slave)        I/D pmem ports and L2 mem port
//   perf_i_grants, perf_d_grants, perf_contended (32b each)
//                      only when ARB_PERF_EN is defined
module l2_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  l2_port_arbiter_if.slave  bus
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_contended
`endif
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       req_i, req_d, grant_i, grant_d;

  assign req_i = bus.arb_icache_read | bus.arb_icache_write;
  assign req_d = bus.arb_dcache_read | bus.arb_dcache_write;

  // Grant decision only matters in IDLE; it is registered on the next edge.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (req_i && (!req_d || starve_cnt == LIMIT)) grant_i = 1'b1;
      else if (req_d)                               grant_d = 1'b1;
    end
  end

  // State register and starvation counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant_i)
        starve_cnt <= '0;
      else if (grant_d && req_i && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Next-state logic. A requester that drops early does not end the
  // transaction; only the L2 response does.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_i)      state_nxt = SERVE_I;
        else if (grant_d) state_nxt = SERVE_D;
      end
      SERVE_I: if (bus.arb_mem_resp) state_nxt = IDLE;
      SERVE_D: if (bus.arb_mem_resp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. Read is masked when a requester illegally asserts both,
  // so L2 never sees read and write together.
  always_comb begin
    bus.arb_mem_read    = 1'b0;
    bus.arb_mem_write   = 1'b0;
    bus.arb_mem_address = '0;
    bus.arb_mem_wdata   = '0;
    bus.arb_icache_resp = 1'b0;
    bus.arb_dcache_resp = 1'b0;
    case (state)
      SERVE_I: begin
        bus.arb_mem_write   = bus.arb_icache_write;
        bus.arb_mem_read    = bus.arb_icache_read & ~bus.arb_icache_write;
        bus.arb_mem_address = bus.arb_icache_address;
        bus.arb_mem_wdata   = bus.arb_icache_wdata;
        bus.arb_icache_resp = bus.arb_mem_resp;
      end
      SERVE_D: begin
        bus.arb_mem_write   = bus.arb_dcache_write;
        bus.arb_mem_read    = bus.arb_dcache_read & ~bus.arb_dcache_write;
        bus.arb_mem_address = bus.arb_dcache_address;
        bus.arb_mem_wdata   = bus.arb_dcache_wdata;
        bus.arb_dcache_resp = bus.arb_mem_resp;
      end
      default: ;
    endcase
  end

  assign bus.arb_icache_rdata = bus.arb_mem_rdata;
  assign bus.arb_dcache_rdata = bus.arb_mem_rdata;

`ifdef ARB_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_contended <= '0;
    end else begin
      if (grant_i) perf_i_grants <= perf_i_grants + 32'd1;
      if (grant_d) perf_d_grants <= perf_d_grants + 32'd1;
      if (state == IDLE && req_i && req_d) perf_contended <= perf_contended + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed stimulus for l2_port_arbiter. Each test pushes
// the transactions L2 should see (in order) into a queue; a monitor pops one
// whenever a new L2 request appears and checks routing of the response.
module tb_l2_port_arbiter;

  typedef struct {
    bit           port_d;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  l2_port_arbiter_if bus ();

`ifdef ARB_PERF_EN
  logic [31:0] perf_i_grants, perf_d_grants, perf_contended;
  logic [31:0] snap_i = '0, snap_d = '0, snap_c = '0;
`endif

  l2_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef ARB_PERF_EN
    ,
    .perf_i_grants  (perf_i_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_contended (perf_contended)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t expq[$];

  logic [255:0] l2_data = '0;
  bit           l2_en   = 1'b1;
  int           stray_req = 0;
  int           stray_ack = 0;

  assign bus.arb_mem_rdata = l2_data;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push(input bit port_d, input bit wr, input logic [31:0] addr,
                      input logic [255:0] wdata);
    exp_t e;
    e.port_d = port_d; e.wr = wr; e.addr = addr; e.wdata = wdata;
    expq.push_back(e);
  endtask

  // L2 model: answers each request after two cycles, plus optional stray pulses.
  initial begin
    int age = 0;
    bus.arb_mem_resp = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.arb_mem_resp = 1'b0;
      if (stray_req != stray_ack) begin
        bus.arb_mem_resp = 1'b1;
        stray_ack = stray_req;
      end else if (l2_en && reset_n && (bus.arb_mem_read || bus.arb_mem_write)) begin
        age++;
        if (age == 2) begin
          bus.arb_mem_resp = 1'b1;
          age = 0;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Monitor: pops an expectation at the start of every L2 transaction.
  initial begin
    bit   in_txn = 1'b0;
    bit   cur_d  = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_txn = 1'b0;
      end else begin
        chk("rw_exclusive", 256'(bus.arb_mem_read & bus.arb_mem_write), 256'd0);
        if (!in_txn && (bus.arb_mem_read || bus.arb_mem_write)) begin
          if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req: got addr %0h want none", bus.arb_mem_address);
          end else begin
            e = expq.pop_front();
            chk("mem_address", 256'(bus.arb_mem_address), 256'(e.addr));
            chk("mem_write", 256'(bus.arb_mem_write), 256'(e.wr));
            chk("mem_read", 256'(bus.arb_mem_read), 256'(!e.wr));
            if (e.wr) chk("mem_wdata", bus.arb_mem_wdata, e.wdata);
            cur_d = e.port_d;
          end
          in_txn = 1'b1;
        end
        if (bus.arb_mem_resp && in_txn) begin
          if (cur_d) begin
            chk("d_resp", 256'(bus.arb_dcache_resp), 256'd1);
            chk("i_resp_quiet", 256'(bus.arb_icache_resp), 256'd0);
            chk("d_rdata", bus.arb_dcache_rdata, l2_data);
          end else begin
            chk("i_resp", 256'(bus.arb_icache_resp), 256'd1);
            chk("d_resp_quiet", 256'(bus.arb_dcache_resp), 256'd0);
            chk("i_rdata", bus.arb_icache_rdata, l2_data);
          end
          in_txn = 1'b0;
        end else begin
          chk("i_resp_idle", 256'(bus.arb_icache_resp), 256'd0);
          chk("d_resp_idle", 256'(bus.arb_dcache_resp), 256'd0);
        end
      end
    end
  end

  // Keeps requests asserted until each port has seen its quota of responses.
  task automatic serve(input int ni, input int nd);
    int i_left = ni;
    int d_left = nd;
    int cyc = 0;
    bit ir, dr;
    while ((i_left > 0 || d_left > 0) && cyc < 400) begin
      @(negedge clk);
      ir = bus.arb_icache_resp;
      dr = bus.arb_dcache_resp;
      @(posedge clk); #1;
      cyc++;
      if (ir && i_left > 0) begin
        i_left--;
        if (i_left == 0) begin
          bus.arb_icache_read  = 1'b0;
          bus.arb_icache_write = 1'b0;
`ifdef ARB_PERF_EN
          snap_i = perf_i_grants; snap_d = perf_d_grants; snap_c = perf_contended;
`endif
        end
      end
      if (dr && d_left > 0) begin
        d_left--;
        if (d_left == 0) begin
          bus.arb_dcache_read  = 1'b0;
          bus.arb_dcache_write = 1'b0;
        end
      end
    end
    if (i_left > 0 || d_left > 0) begin
      total++; bad++;
      $display("FAIL serve_timeout: left i=%0d d=%0d want 0", i_left, d_left);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.arb_icache_read = 1'b1;  bus.arb_icache_write = 1'b0;
    bus.arb_icache_address = 32'h0000_1000; bus.arb_icache_wdata = '0;
    bus.arb_dcache_read = 1'b1;  bus.arb_dcache_write = 1'b0;
    bus.arb_dcache_address = 32'h0000_2000; bus.arb_dcache_wdata = '0;

    // Reset held with both reading: no grant, all outputs quiet.
    repeat (3) @(negedge clk);
    chk("rst_mem_read", 256'(bus.arb_mem_read), 256'd0);
    chk("rst_mem_write", 256'(bus.arb_mem_write), 256'd0);
    chk("rst_mem_address", 256'(bus.arb_mem_address), 256'd0);
    chk("rst_mem_wdata", bus.arb_mem_wdata, 256'd0);
    chk("rst_i_resp", 256'(bus.arb_icache_resp), 256'd0);
    chk("rst_d_resp", 256'(bus.arb_dcache_resp), 256'd0);
`ifdef ARB_PERF_EN
    chk("rst_perf_i", 256'(perf_i_grants), 256'd0);
    chk("rst_perf_c", 256'(perf_contended), 256'd0);
`endif
    l2_data = {8{32'h1111_2222}};
    push(1'b1, 1'b0, 32'h0000_2000, '0);
    push(1'b0, 1'b0, 32'h0000_1000, '0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("release_serve_d_read", 256'(bus.arb_mem_read), 256'd1);
    chk("release_serve_d_addr", 256'(bus.arb_mem_address), 256'h2000);
    serve(1, 1);

    // Lone I read: one-cycle request latency, zero-cycle response.
    l2_data = {32{8'hA5}};
    bus.arb_icache_read = 1'b1; bus.arb_icache_address = 32'h0000_1000;
    push(1'b0, 1'b0, 32'h0000_1000, '0);
    @(negedge clk);
    chk("idle_not_forwarded", 256'(bus.arb_mem_read), 256'd0);
    @(negedge clk);
    chk("lone_i_read", 256'(bus.arb_mem_read), 256'd1);
    chk("lone_i_addr", 256'(bus.arb_mem_address), 256'h1000);
    serve(1, 0);

    // D write against I read: D first with its own data, then I.
    l2_data = {8{32'hDEAD_BEEF}};
    bus.arb_dcache_write = 1'b1; bus.arb_dcache_read = 1'b0;
    bus.arb_dcache_address = 32'h0000_0080; bus.arb_dcache_wdata = '1;
    bus.arb_icache_read = 1'b1; bus.arb_icache_address = 32'h0000_1000;
    push(1'b1, 1'b1, 32'h0000_0080, '1);
    push(1'b0, 1'b0, 32'h0000_1000, '0);
    serve(1, 1);

    // Illegal read+write from D: only the write reaches L2.
    bus.arb_dcache_write = 1'b1; bus.arb_dcache_read = 1'b1;
    bus.arb_dcache_address = 32'h0000_0040; bus.arb_dcache_wdata = {8{32'h0123_4567}};
    push(1'b1, 1'b1, 32'h0000_0040, {8{32'h0123_4567}});
    serve(0, 1);

    // Stray L2 response in IDLE: ignored, then a normal D read.
    stray_req++;
    repeat (3) @(posedge clk);
    #1;
    l2_data = {8{32'h5A5A_0F0F}};
    bus.arb_dcache_read = 1'b1; bus.arb_dcache_address = 32'h0000_0500;
    push(1'b1, 1'b0, 32'h0000_0500, '0);
    serve(0, 1);

    // Reset during SERVE_I: read drops without waiting for a clock edge.
    l2_en = 1'b0;
    bus.arb_icache_read = 1'b1; bus.arb_icache_address = 32'h0000_3000;
    push(1'b0, 1'b0, 32'h0000_3000, '0);
    begin
      int w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!bus.arb_mem_read && w < 10);
    end
    chk("serve_i_started", 256'(bus.arb_mem_read), 256'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_drop_read", 256'(bus.arb_mem_read), 256'd0);
    chk("async_drop_addr", 256'(bus.arb_mem_address), 256'd0);
`ifdef ARB_PERF_EN
    chk("perf_cleared", 256'(perf_d_grants), 256'd0);
`endif
    bus.arb_icache_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    l2_en = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 256'(bus.arb_mem_read), 256'd0);
    @(posedge clk); #1;

    // Starvation: both reading continuously, grant order D,D,D,D,I twice.
    l2_data = {8{32'hCAFE_F00D}};
    bus.arb_icache_read = 1'b1; bus.arb_icache_address = 32'h0000_1000;
    bus.arb_dcache_read = 1'b1; bus.arb_dcache_write = 1'b0;
    bus.arb_dcache_address = 32'h0000_2000;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) push(1'b1, 1'b0, 32'h0000_2000, '0);
      push(1'b0, 1'b0, 32'h0000_1000, '0);
    end
    push(1'b1, 1'b0, 32'h0000_2000, '0);
    serve(2, 9);
`ifdef ARB_PERF_EN
    chk("perf_d", 256'(snap_d), 256'd8);
    chk("perf_i", 256'(snap_i), 256'd2);
    chk("perf_contended", 256'(snap_c), 256'd10);
`endif

    repeat (3) @(posedge clk);
    chk("queue_drained", 256'(expq.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
